// File: rtl/pwm_ctrl_pkg.sv
// Shared definitions for the PWM sequencer: state encoding, default widths
// matching pwm_top, and the duty clamp used on requested targets.
package pwm_ctrl_pkg;

   localparam int PWM_R          = 8;
   localparam int PWM_TIMER_BITS = 8;
   localparam int PWM_DT_WIDTH   = 8;
   localparam int PWM_RP_W       = 8;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_RAMP_UP = 3'd1,
      ST_RUN     = 3'd2,
      ST_RAMP_DN = 3'd3,
      ST_FAULT   = 3'd4
   } seq_state_t;

   // Limits a requested duty to 2^r, which is 100 % at resolution r.
   function automatic int unsigned clamp_duty(input int unsigned d, input int unsigned r);
      int unsigned full;
      full = 32'd1 << r;
      return (d > full) ? full : d;
   endfunction

endpackage

// File: rtl/duty_ramp_step.sv
// Combinational saturating step of the duty value toward a goal; the extra
// headroom bit keeps duty+s and goal+s from wrapping.
module duty_ramp_step #(
   parameter int R = 8
) (
   input  logic [R:0] duty,
   input  logic [R:0] goal,
   input  logic [R:0] step,
   output logic [R:0] next_duty,
   output logic       done
);

   logic [R+1:0] duty_w;
   logic [R+1:0] goal_w;
   logic [R+1:0] step_w;
   logic [R+1:0] sum_w;
   logic [R+1:0] lim_w;
   logic [R+1:0] diff_w;

   assign duty_w = {1'b0, duty};
   assign goal_w = {1'b0, goal};
   assign step_w = {1'b0, step};
   assign sum_w  = duty_w + step_w;
   assign lim_w  = goal_w + step_w;
   assign diff_w = duty_w - step_w;

   // Below the goal we climb and stop at it; otherwise we descend and snap
   // to the goal once a full step would overshoot it.
   always_comb begin
      next_duty = goal;
      if (duty_w < goal_w) begin
         next_duty = (sum_w > goal_w) ? goal : sum_w[R:0];
      end else begin
         next_duty = (duty_w <= lim_w) ? goal : diff_w[R:0];
      end
   end

   assign done = (duty == goal);

endmodule

// File: rtl/pwm_seq_ctrl.sv
// Sequencer for the PWM/dead-time datapath: soft start/stop ramping,
// period-aligned shadow loading of frequency and dead time, latched fault.
module pwm_seq_ctrl
   import pwm_ctrl_pkg::*;
#(
   parameter int R          = PWM_R,
   parameter int TIMER_BITS = PWM_TIMER_BITS,
   parameter int DT_WIDTH   = PWM_DT_WIDTH,
   parameter int RP_W       = PWM_RP_W
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  enable,
   input  logic                  fault,
   input  logic                  fault_clr,
   input  logic                  period_start,
   input  logic [R:0]            target_duty,
   input  logic [R:0]            ramp_step,
   input  logic [RP_W-1:0]       ramp_periods,
   input  logic [TIMER_BITS-1:0] final_value_in,
   input  logic [DT_WIDTH-1:0]   dt_value_in,
   output logic [R:0]            duty,
   output logic [TIMER_BITS-1:0] FINAL_VALUE,
   output logic [DT_WIDTH-1:0]   dt_value,
   output logic                  gate_en,
   output logic [2:0]            state,
   output logic                  at_target
);

   seq_state_t            state_q;
   seq_state_t            state_n;
   logic [R:0]            target_clamped;
   logic [R:0]            goal;
   logic [R:0]            step_eff;
   logic [R:0]            step_duty;
   logic [R:0]            duty_n;
   logic                  step_done;
   logic [RP_W-1:0]       rp_eff;
   logic [RP_W-1:0]       cnt_q;
   logic [RP_W-1:0]       cnt_n;
   logic [RP_W:0]         cnt_inc;
   logic                  ramp_hit;
   logic [TIMER_BITS-1:0] fv_n;
   logic [DT_WIDTH-1:0]   dt_n;
   logic                  gate_n;
   logic                  at_target_n;
   logic                  latch_q;
   logic                  latch_n;

   assign target_clamped = (R+1)'(clamp_duty(32'(target_duty), R));
   assign step_eff       = (ramp_step == '0) ? (R+1)'(1) : ramp_step;
   assign rp_eff         = (ramp_periods == '0) ? RP_W'(1) : ramp_periods;
   assign goal           = enable ? target_clamped : '0;
   assign cnt_inc        = {1'b0, cnt_q} + (RP_W+1)'(1);
   assign ramp_hit       = period_start && (cnt_inc == {1'b0, rp_eff});
   assign state          = state_q;

   duty_ramp_step #(.R(R)) u_step (
      .duty      (duty),
      .goal      (goal),
      .step      (step_eff),
      .next_duty (step_duty),
      .done      (step_done)
   );

   // Next-state and next-output logic; fault overrides everything.
   always_comb begin
      state_n = state_q;
      duty_n  = duty;
      cnt_n   = cnt_q;
      gate_n  = gate_en;
      latch_n = latch_q;
      fv_n    = period_start ? final_value_in : FINAL_VALUE;
      dt_n    = period_start ? dt_value_in : dt_value;
      if (fault) begin
         state_n = ST_FAULT;
         duty_n  = '0;
         gate_n  = 1'b0;
         latch_n = 1'b1;
         cnt_n   = '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               duty_n = '0;
               gate_n = 1'b0;
               cnt_n  = '0;
               fv_n   = final_value_in;
               dt_n   = dt_value_in;
               if (enable && !latch_q) begin
                  state_n = ST_RAMP_UP;
                  gate_n  = 1'b1;
               end
            end
            ST_RAMP_UP, ST_RAMP_DN: begin
               gate_n = 1'b1;
               if (period_start) begin
                  cnt_n = ramp_hit ? '0 : cnt_inc[RP_W-1:0];
               end
               if (ramp_hit) begin
                  duty_n = step_duty;
               end
               // Direction follows the registered duty, so a goal reversal
               // just flips the state and the ramp continues from here.
               if (step_done) begin
                  state_n = enable ? ST_RUN : ST_IDLE;
                  gate_n  = enable;
               end else if (duty < goal) begin
                  state_n = ST_RAMP_UP;
               end else begin
                  state_n = ST_RAMP_DN;
               end
            end
            ST_RUN: begin
               gate_n = 1'b1;
               cnt_n  = '0;
               if (goal > duty) begin
                  state_n = ST_RAMP_UP;
               end else if (goal < duty) begin
                  state_n = ST_RAMP_DN;
               end else if (!enable) begin
                  state_n = ST_IDLE;
                  gate_n  = 1'b0;
               end
            end
            ST_FAULT: begin
               duty_n = '0;
               gate_n = 1'b0;
               cnt_n  = '0;
               if (fault_clr && !enable) begin
                  state_n = ST_IDLE;
                  latch_n = 1'b0;
               end
            end
            default: begin
               state_n = ST_IDLE;
               duty_n  = '0;
               gate_n  = 1'b0;
               cnt_n   = '0;
            end
         endcase
      end
      at_target_n = (state_n == ST_RUN) && (duty_n == target_clamped);
   end

   // All outputs and internal state are registered here.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         duty        <= '0;
         FINAL_VALUE <= '0;
         dt_value    <= '0;
         gate_en     <= 1'b0;
         at_target   <= 1'b0;
         cnt_q       <= '0;
         latch_q     <= 1'b0;
      end else begin
         state_q     <= state_n;
         duty        <= duty_n;
         FINAL_VALUE <= fv_n;
         dt_value    <= dt_n;
         gate_en     <= gate_n;
         at_target   <= at_target_n;
         cnt_q       <= cnt_n;
         latch_q     <= latch_n;
      end
   end

endmodule

// File: tb/tb_pwm_seq_ctrl.sv
// Directed bench for pwm_seq_ctrl: soft start/stop, fault latch, clamping,
// period-aligned reconfiguration, goal reversal and asynchronous reset.
module tb_pwm_seq_ctrl;

   logic       clk;
   logic       reset;
   logic       enable;
   logic       fault;
   logic       fault_clr;
   logic       period_start;
   logic [8:0] target_duty;
   logic [8:0] ramp_step;
   logic [7:0] ramp_periods;
   logic [7:0] final_value_in;
   logic [7:0] dt_value_in;
   logic [8:0] duty;
   logic [7:0] final_value;
   logic [7:0] dt_value;
   logic       gate_en;
   logic [2:0] state;
   logic       at_target;

   int check_count = 0;
   int pass_count  = 0;

   pwm_seq_ctrl dut (
      .clk            (clk),
      .reset          (reset),
      .enable         (enable),
      .fault          (fault),
      .fault_clr      (fault_clr),
      .period_start   (period_start),
      .target_duty    (target_duty),
      .ramp_step      (ramp_step),
      .ramp_periods   (ramp_periods),
      .final_value_in (final_value_in),
      .dt_value_in    (dt_value_in),
      .duty           (duty),
      .FINAL_VALUE    (final_value),
      .dt_value       (dt_value),
      .gate_en        (gate_en),
      .state          (state),
      .at_target      (at_target)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input int unsigned actual, input int unsigned expected);
      check_count++;
      if (actual == expected) begin
         pass_count++;
      end else begin
         $display("[TB] FAIL %s: got %0d expected %0d", tag, actual, expected);
      end
   endtask

   task automatic wait_clks(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic pulse_period();
      period_start = 1'b1;
      @(posedge clk);
      #1;
      period_start = 1'b0;
   endtask

   task automatic run_period();
      wait_clks(9);
      pulse_period();
   endtask

   int unsigned up_tab[5];
   int unsigned dn_tab[5];

   initial begin
      up_tab = '{0, 30, 60, 90, 100};
      dn_tab = '{100, 70, 40, 10, 0};

      reset          = 1'b1;
      enable         = 1'b0;
      fault          = 1'b0;
      fault_clr      = 1'b0;
      period_start   = 1'b0;
      target_duty    = 9'd100;
      ramp_step      = 9'd30;
      ramp_periods   = 8'd2;
      final_value_in = 8'd50;
      dt_value_in    = 8'd3;

      repeat (2) @(posedge clk);
      #1;
      checkOutput("rst_duty", duty, 0);
      checkOutput("rst_fv", final_value, 0);
      checkOutput("rst_dt", dt_value, 0);
      checkOutput("rst_gate", gate_en, 0);
      checkOutput("rst_state", state, 0);
      checkOutput("rst_at_target", at_target, 0);
      reset = 1'b0;

      // Soft start
      enable = 1'b1;
      wait_clks(1);
      checkOutput("start_state", state, 1);
      checkOutput("start_gate", gate_en, 1);
      checkOutput("start_duty", duty, 0);
      checkOutput("idle_fv_load", final_value, 50);
      for (int i = 1; i <= 8; i++) begin
         run_period();
         checkOutput($sformatf("up_duty_%0d", i), duty, up_tab[i/2]);
      end
      checkOutput("up_last_state", state, 1);
      wait_clks(1);
      checkOutput("run_state", state, 2);
      checkOutput("run_at_target", at_target, 1);

      // Soft stop
      enable = 1'b0;
      wait_clks(1);
      checkOutput("dn_state", state, 3);
      checkOutput("dn_gate", gate_en, 1);
      checkOutput("dn_at_target", at_target, 0);
      for (int i = 1; i <= 8; i++) begin
         run_period();
         checkOutput($sformatf("dn_duty_%0d", i), duty, dn_tab[i/2]);
      end
      wait_clks(1);
      checkOutput("stop_state", state, 0);
      checkOutput("stop_gate", gate_en, 0);

      // Fault mid-ramp
      enable = 1'b1;
      wait_clks(1);
      checkOutput("f_ramp_state", state, 1);
      for (int i = 1; i <= 4; i++) run_period();
      checkOutput("f_pre_duty", duty, 60);
      wait_clks(3);
      fault = 1'b1;
      wait_clks(1);
      checkOutput("f_duty", duty, 0);
      checkOutput("f_gate", gate_en, 0);
      checkOutput("f_state", state, 4);
      enable    = 1'b0;
      fault_clr = 1'b1;
      wait_clks(1);
      checkOutput("f_clr_while_fault", state, 4);
      fault  = 1'b0;
      enable = 1'b1;
      wait_clks(1);
      checkOutput("f_clr_while_enable", state, 4);
      checkOutput("f_gate_hold", gate_en, 0);
      fault_clr = 1'b0;
      enable    = 1'b0;
      wait_clks(1);
      checkOutput("f_no_clr", state, 4);
      fault_clr = 1'b1;
      wait_clks(1);
      checkOutput("f_exit_state", state, 0);
      fault_clr      = 1'b0;
      final_value_in = 8'd9;
      dt_value_in    = 8'd7;
      wait_clks(1);
      checkOutput("idle_fv_follow", final_value, 9);
      checkOutput("idle_dt_follow", dt_value, 7);

      // Clamp and zero-parameter substitution
      final_value_in = 8'd50;
      dt_value_in    = 8'd3;
      target_duty    = 9'd400;
      ramp_step      = 9'd0;
      ramp_periods   = 8'd0;
      enable         = 1'b1;
      wait_clks(1);
      checkOutput("clamp_state", state, 1);
      for (int i = 1; i <= 256; i++) begin
         run_period();
         if (i < 4 || i > 253) checkOutput($sformatf("clamp_duty_%0d", i), duty, i);
      end
      wait_clks(1);
      checkOutput("clamp_run_state", state, 2);
      checkOutput("clamp_at_target", at_target, 1);
      run_period();
      checkOutput("clamp_hold_duty", duty, 256);

      // Boundary-aligned reconfiguration in RUN
      wait_clks(4);
      checkOutput("cfg_fv_before", final_value, 50);
      final_value_in = 8'd77;
      dt_value_in    = 8'd5;
      wait_clks(4);
      checkOutput("cfg_fv_mid", final_value, 50);
      checkOutput("cfg_dt_mid", dt_value, 3);
      pulse_period();
      checkOutput("cfg_fv_after", final_value, 77);
      checkOutput("cfg_dt_after", dt_value, 5);

      // Goal reversal mid-ramp
      ramp_step    = 9'd10;
      ramp_periods = 8'd1;
      target_duty  = 9'd200;
      wait_clks(1);
      checkOutput("rev_dn_state", state, 3);
      run_period();
      checkOutput("rev_dn_duty_1", duty, 246);
      run_period();
      checkOutput("rev_dn_duty_2", duty, 236);
      target_duty = 9'd250;
      wait_clks(1);
      checkOutput("rev_up_state", state, 1);
      checkOutput("rev_up_duty_hold", duty, 236);
      run_period();
      checkOutput("rev_up_duty_1", duty, 246);
      run_period();
      checkOutput("rev_up_duty_sat", duty, 250);
      wait_clks(1);
      checkOutput("rev_run_state", state, 2);
      checkOutput("rev_at_target", at_target, 1);

      // Asynchronous reset mid-ramp
      target_duty = 9'd100;
      wait_clks(1);
      run_period();
      checkOutput("ar_pre_duty", duty, 240);
      #2;
      reset = 1'b1;
      #1;
      checkOutput("ar_duty", duty, 0);
      checkOutput("ar_state", state, 0);
      checkOutput("ar_gate", gate_en, 0);
      checkOutput("ar_fv", final_value, 0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      wait_clks(1);
      checkOutput("ar_resume_state", state, 1);
      checkOutput("ar_resume_duty", duty, 0);

      $display("%0d/%0d checks passed", pass_count, check_count);
      $finish;
   end

endmodule
